input_stream_reader: RTL and testbench
======================================

Name: input_stream_reader

Overview:
- Per-queue read engine inside afu_manager. It turns one input-buffer configuration (base address and line count) into a stream of 64-byte cache-line read requests toward the CCI read channel.
- It captures the matching read responses into a local first-word-fall-through FIFO and presents them to the accelerator as a 512-bit data stream.
- Flow control is credit-based, so the FIFO can never overflow.
- MPF response sorting is enabled; read responses for this queue arrive in request order.

Parameters:
- QUEUE_ID, 0, 8-bit identifier. Matched against conf[103:96] and carried in mdata[15:8].
- FIFO_DEPTH, 32, data FIFO entries. Must be a power of two, at least 4 and at most 256.
- ADDR_WIDTH, 48, byte-address width of req_rd_addr.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  run enable for this queue (start_afus bit)
- conf_valid  in  2  configuration strobe; type 1 = input-data configuration
- conf  in  128  [63:0] base byte address; [95:64] number of cache lines; [103:96] queue id
- req_rd_en  out  1  read request valid
- req_rd_ready  in  1  request accepted this cycle
- req_rd_addr  out  ADDR_WIDTH  byte address of the request
- req_rd_mdata  out  16  {QUEUE_ID, request index[7:0]}
- resp_rd_valid  in  1  read response valid
- resp_rd_data  in  512  response cache line
- resp_rd_mdata  in  16  response mdata
- dout_valid  out  1  FIFO not empty
- dout  out  512  FIFO head
- dout_read  in  1  pop FIFO head
- done  out  1  all lines received and FIFO drained
- cl_count  out  32  lines received so far

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; all counters, the FIFO and the stored configuration are cleared.
  - req_rd_en=0, dout_valid=0, done=0, cl_count=0.
  - Reset mid-operation drops all in-flight bookkeeping. Responses arriving after reset are accepted into the FIFO only if the block is in RUN again.
- Configuration capture:
  - Captured when conf_valid==1 and conf[103:96]==QUEUE_ID, in IDLE, CONFIGURED or DONE.
  - base is latched with bits [5:0] forced to 0; num_cl latched from conf[95:64]; state moves to CONFIGURED; counters, done and cl_count clear.
  - Configuration writes in RUN are ignored.
- States: IDLE -> CONFIGURED (configuration captured) -> RUN (start=1) -> DONE (received==num_cl and FIFO empty). DONE -> CONFIGURED on a new configuration.
- num_cl=0: CONFIGURED goes to DONE on the first cycle with start=1. No requests are issued.
- Issue rule:
  - req_rd_en = (state==RUN) && start && (issued<num_cl) && (outstanding+occupancy < FIFO_DEPTH).
  - req_rd_en is combinational from registers only; it does not depend on req_rd_ready.
  - The request is accepted when req_rd_en && req_rd_ready; issued and outstanding then increment at that edge.
  - req_rd_addr = base + issued*64, truncated to ADDR_WIDTH and wrapping modulo 2^ADDR_WIDTH. req_rd_mdata = {QUEUE_ID, issued[7:0]}.
  - Address and mdata are stable while req_rd_en=1 and not yet accepted.
- start deasserted in RUN: issuing pauses and the state is held. Responses are still accepted and the FIFO still drains. Issuing resumes when start returns to 1.
- Response rule:
  - A response is accepted when resp_rd_valid && resp_rd_mdata[15:8]==QUEUE_ID && state==RUN.
  - On acceptance: push resp_rd_data, decrement outstanding, increment cl_count.
  - Responses with a foreign queue id are ignored.
  - An accepted response with outstanding==0 is a protocol error: the data is dropped and a simulation-only error message is printed.
- Simultaneous events in one cycle:
  - Request acceptance and response: outstanding is unchanged.
  - Push and pop: occupancy is unchanged.
  - Because of the credit rule, a push into a full FIFO cannot occur.
- FIFO behaviour:
  - First-word-fall-through; data is visible on dout the cycle after the push, and the pop takes effect at the clock edge.
  - dout_read while empty is ignored. dout holds its last value when dout_valid=0.
- done is registered: it asserts the cycle after the last line is popped and stays high until the next configuration or reset.
- Width rules: issued, received and cl_count are 32 bits. outstanding and occupancy are log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Basic stream: QUEUE_ID=3, FIFO_DEPTH=32, conf base=0x1000, num_cl=4, id=3; start=1; req_rd_ready=1; in-order responses; dout_read=1 -> 4 requests with addresses 0x1000, 0x1040, 0x1080, 0x10C0 and mdata 0x0300..0x0303. The 4 lines appear on dout in order, cl_count=4, done=1.
- Backpressure: num_cl=100, FIFO_DEPTH=32, dout_read=0, responses returned immediately -> exactly 32 requests issued, then req_rd_en=0. Popping 5 lines allows exactly 5 more requests.
- Filtering: responses tagged 0x0500 interleaved with valid ones for QUEUE_ID=3 -> only the id-3 lines are stored; cl_count counts only those.
- Boundaries: num_cl=0 -> done=1 one cycle after start, no req_rd_en. Base 0x1007 -> first address 0x1000. Base 0xFFFF_FFFF_FFC0 -> second address wraps to 0x0.
- Pause/reset: deassert start after 2 of 8 requests -> no further requests, and outstanding responses are still stored. Reassert start -> requests resume at the 3rd address. Drive rst=0 mid-run -> all outputs return to their reset values the next cycle.
- Reconfiguration while in RUN is ignored. A new configuration in DONE clears done and cl_count and restarts from the new base.

Source files
------------

// File: rtl/input_stream_reader.sv
// input_stream_reader: per-queue cache-line read engine with a credit-limited FWFT data FIFO
module input_stream_reader #(
  parameter logic [7:0] QUEUE_ID   = 8'd0,
  parameter int         FIFO_DEPTH = 32,
  parameter int         ADDR_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            conf_valid,
  input  logic [127:0]          conf,
  output logic                  req_rd_en,
  input  logic                  req_rd_ready,
  output logic [ADDR_WIDTH-1:0] req_rd_addr,
  output logic [15:0]           req_rd_mdata,
  input  logic                  resp_rd_valid,
  input  logic [511:0]          resp_rd_data,
  input  logic [15:0]           resp_rd_mdata,
  output logic                  dout_valid,
  output logic [511:0]          dout,
  input  logic                  dout_read,
  output logic                  done,
  output logic [31:0]           cl_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CONFIGURED, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           num_cl_q, num_cl_d;
  logic [31:0]           issued_q, issued_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [511:0]          last_q, last_d;
  logic [511:0]          mem [FIFO_DEPTH];
  logic                  cfg, req_acc, resp_hit, push, pop;
  logic                  unused_ok;

  // Configuration is taken in every state except RUN; base is forced to a cache-line boundary.
  assign cfg       = conf_valid == 2'd1 && conf[103:96] == QUEUE_ID && state_q != RUN;
  assign req_acc   = req_rd_en && req_rd_ready;
  assign resp_hit  = resp_rd_valid && resp_rd_mdata[15:8] == QUEUE_ID && state_q == RUN;
  assign push      = resp_hit && outst_q != '0;
  assign pop       = dout_read && occ_q != '0;
  assign unused_ok = ^{conf[127:104], conf[63:ADDR_WIDTH], conf[5:0], resp_rd_mdata[7:0]};

  assign req_rd_addr  = base_q + ADDR_WIDTH'({issued_q, 6'b0});
  assign req_rd_mdata = {QUEUE_ID, issued_q[7:0]};
  assign dout_valid   = occ_q != '0;
  assign dout         = dout_valid ? mem[rd_q] : last_q;
  assign cl_count     = cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; DONE is entered as soon as the final line is popped so done rises right after the pop edge
  always_comb begin
    state_d = state_q;
    if (cfg) state_d = CONFIGURED;
    else if (state_q == CONFIGURED && start) state_d = num_cl_q == '0 ? DONE : RUN;
    else if (state_q == RUN && cnt_d == num_cl_q && occ_d == '0) state_d = DONE;
  end

  // Outputs; a request needs a free FIFO credit counting both stored and in-flight lines
  always_comb begin
    req_rd_en = state_q == RUN && start && issued_q < num_cl_q && ({1'b0, outst_q} + {1'b0, occ_q}) < DEPTH;
    done      = state_q == DONE;
  end

  // Datapath next values: request/response bookkeeping and FIFO pointers
  always_comb begin
    base_d   = cfg ? {conf[ADDR_WIDTH-1:6], 6'b0} : base_q;
    num_cl_d = cfg ? conf[95:64] : num_cl_q;
    issued_d = cfg ? '0 : issued_q + 32'(req_acc);
    cnt_d    = cfg ? '0 : cnt_q + 32'(push);
    outst_d  = cfg ? '0 : outst_q + CW'(req_acc) - CW'(push);
    occ_d    = occ_q + CW'(push) - CW'(pop);
    wr_d     = wr_q + PW'(push);
    rd_d     = rd_q + PW'(pop);
    last_d   = pop ? mem[rd_q] : last_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q   <= '0;
      num_cl_q <= '0;
      issued_q <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
      occ_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      last_q   <= '0;
    end else begin
      base_q   <= base_d;
      num_cl_q <= num_cl_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      occ_q    <= occ_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      last_q   <= last_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= resp_rd_data;
  end

  // A response with nothing outstanding is a protocol error; its data is dropped
  always_ff @(posedge clk) begin
    if (rst && resp_hit) assert (outst_q != '0) else $error("input_stream_reader: response with no outstanding request dropped");
  end
endmodule

// File: tb/tb_input_stream_reader.sv
// tb_input_stream_reader: randomized directed test of input_stream_reader against a queue-based model
module tb_input_stream_reader;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   conf_valid;
  logic [127:0] conf;
  logic         req_rd_en, req_rd_ready;
  logic [47:0]  req_rd_addr;
  logic [15:0]  req_rd_mdata;
  logic         resp_rd_valid;
  logic [511:0] resp_rd_data;
  logic [15:0]  resp_rd_mdata;
  logic         dout_valid;
  logic [511:0] dout;
  logic         dout_read, done;
  logic [31:0]  cl_count;

  input_stream_reader #(.QUEUE_ID(8'd3), .FIFO_DEPTH(32), .ADDR_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .start(start), .conf_valid(conf_valid), .conf(conf),
    .req_rd_en(req_rd_en), .req_rd_ready(req_rd_ready), .req_rd_addr(req_rd_addr),
    .req_rd_mdata(req_rd_mdata), .resp_rd_valid(resp_rd_valid), .resp_rd_data(resp_rd_data),
    .resp_rd_mdata(resp_rd_mdata), .dout_valid(dout_valid), .dout(dout), .dout_read(dout_read),
    .done(done), .cl_count(cl_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int rdy_pct, rd_pct, resp_pct;
  bit foreign;
  int mst;
  logic [47:0] m_base;
  int unsigned m_num, n_req, m_cl, n_pop;
  logic [47:0]  pend[$];
  logic [7:0]   pend_ix[$];
  logic [511:0] fq[$];
  logic [47:0]  reqlog[$];
  logic [511:0] last_pop;
  bit have_last;
  logic [15:0] salt;

  function automatic logic [511:0] line(logic [47:0] a);
    return {8{salt, a}};
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit exp_en, hit, real_resp;
    logic [47:0] ea;
    req_rd_ready = $urandom_range(99) < rdy_pct;
    dout_read = $urandom_range(99) < rd_pct;
    real_resp = pend.size() > 0 && $urandom_range(99) < resp_pct;
    if (real_resp) begin
      resp_rd_valid = 1'b1; resp_rd_mdata = {8'd3, pend_ix[0]}; resp_rd_data = line(pend[0]);
    end else if (foreign && $urandom_range(99) < 40) begin
      resp_rd_valid = 1'b1; resp_rd_mdata = {8'h05, 8'($urandom)}; resp_rd_data = {16{$urandom}};
    end else resp_rd_valid = 1'b0;
    #1;
    exp_en = mst == 2 && start && n_req < m_num && pend.size() + fq.size() < 32;
    chk("req_rd_en", 512'(req_rd_en), 512'(exp_en));
    chk("done", 512'(done), 512'(mst == 3));
    chk("cl_count", 512'(cl_count), 512'(m_cl));
    chk("dout_valid", 512'(dout_valid), 512'(fq.size() != 0));
    if (fq.size() != 0) chk("dout", dout, fq[0]);
    else if (have_last) chk("dout_hold", dout, last_pop);
    if (req_rd_en && req_rd_ready) begin
      ea = m_base + 48'(n_req) * 48'd64;
      chk("req_addr", 512'(req_rd_addr), 512'(ea));
      chk("req_mdata", 512'(req_rd_mdata), 512'({8'd3, 8'(n_req)}));
      pend.push_back(ea); pend_ix.push_back(8'(n_req)); reqlog.push_back(ea); n_req++;
    end
    if (fq.size() != 0 && dout_read) begin
      last_pop = fq.pop_front(); have_last = 1'b1; n_pop++;
    end
    if (real_resp) begin
      fq.push_back(line(pend.pop_front())); void'(pend_ix.pop_front()); m_cl++;
    end
    hit = conf_valid == 2'd1 && conf[103:96] == 8'd3;
    if (hit && mst != 2) begin
      mst = 1; m_base = {conf[47:6], 6'b0}; m_num = conf[95:64];
      n_req = 0; m_cl = 0; n_pop = 0; reqlog.delete();
    end else if (mst == 1 && start) mst = m_num == 0 ? 3 : 2;
    else if (mst == 2 && m_cl == m_num && fq.size() == 0) mst = 3;
    @(negedge clk);
  endtask

  task automatic configure(logic [63:0] base, logic [31:0] num, logic [7:0] id);
    conf_valid = 2'd1;
    conf = {24'h0, id, num, base};
    cyc();
    conf_valid = 2'd0;
  endtask

  task automatic run_until(int budget);
    int k = 0;
    while (mst != 3 && k < budget) begin cyc(); k++; end
    chk("run_timeout", 512'(mst == 3), 512'(1));
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    resp_rd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_rd_en", 512'(req_rd_en), 512'(0));
    chk("rst_dout_valid", 512'(dout_valid), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_cl_count", 512'(cl_count), 512'(0));
    mst = 0; m_num = 0; n_req = 0; m_cl = 0; n_pop = 0; have_last = 1'b0;
    pend.delete(); pend_ix.delete(); fq.delete(); reqlog.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int k;
    salt = 16'($urandom);
    rst = 1'b0; start = 1'b0; conf_valid = 2'd0; conf = '0;
    req_rd_ready = 1'b0; dout_read = 1'b0; resp_rd_valid = 1'b0; resp_rd_data = '0; resp_rd_mdata = '0;
    foreign = 1'b0; m_base = '0;
    do_reset();

    rdy_pct = 100; rd_pct = 100; resp_pct = 100;
    configure(64'h1000, 4, 8'd3);
    start = 1'b1;
    run_until(200);
    chk("basic_cl", 512'(cl_count), 512'(4));
    chk("basic_done", 512'(done), 512'(1));
    chk("basic_pops", 512'(n_pop), 512'(4));
    chk("basic_nreq", 512'(reqlog.size()), 512'(4));
    chk("basic_a0", 512'(reqlog[0]), 512'(48'h1000));
    chk("basic_a1", 512'(reqlog[1]), 512'(48'h1040));
    chk("basic_a2", 512'(reqlog[2]), 512'(48'h1080));
    chk("basic_a3", 512'(reqlog[3]), 512'(48'h10C0));

    configure(64'h20000, 100, 8'd3);
    rd_pct = 0;
    repeat (60) cyc();
    chk("bp_nreq32", 512'(n_req), 512'(32));
    chk("bp_en_low", 512'(req_rd_en), 512'(0));
    rd_pct = 100;
    repeat (5) cyc();
    rd_pct = 0;
    repeat (30) cyc();
    chk("bp_nreq37", 512'(n_req), 512'(37));
    chk("bp_pops", 512'(n_pop), 512'(5));
    rdy_pct = 70; rd_pct = 60; resp_pct = 50;
    run_until(5000);
    chk("bp_cl", 512'(cl_count), 512'(100));

    configure(64'h50000, 7, 8'd5);
    foreign = 1'b1;
    configure(64'h40000, 20, 8'd3);
    run_until(3000);
    chk("filt_cl", 512'(cl_count), 512'(20));
    foreign = 1'b0;

    start = 1'b0;
    configure(64'h0, 0, 8'd3);
    cyc();
    start = 1'b1;
    cyc();
    chk("zero_done", 512'(done), 512'(1));
    chk("zero_nreq", 512'(n_req), 512'(0));

    start = 1'b0;
    configure(64'h1007, 2, 8'd3);
    start = 1'b1;
    run_until(300);
    chk("align_a0", 512'(reqlog[0]), 512'(48'h1000));

    configure(64'hFFFF_FFFF_FFC0, 3, 8'd3);
    run_until(300);
    chk("wrap_a0", 512'(reqlog[0]), 512'(48'hFFFF_FFFF_FFC0));
    chk("wrap_a1", 512'(reqlog[1]), 512'(48'h0));
    chk("wrap_a2", 512'(reqlog[2]), 512'(48'h40));

    start = 1'b0;
    rdy_pct = 100; rd_pct = 0; resp_pct = 0;
    configure(64'h80000, 8, 8'd3);
    start = 1'b1;
    k = 0;
    while (n_req < 2 && k < 50) begin cyc(); k++; end
    start = 1'b0;
    resp_pct = 100;
    repeat (10) cyc();
    chk("pause_nreq", 512'(n_req), 512'(2));
    chk("pause_cl", 512'(cl_count), 512'(2));
    chk("pause_valid", 512'(dout_valid), 512'(1));
    start = 1'b1; rd_pct = 100;
    run_until(500);
    chk("resume_a2", 512'(reqlog[2]), 512'(48'h80080));

    configure(64'hA0000, 6, 8'd3);
    cyc(); cyc();
    configure(64'hB0000, 2, 8'd3);
    run_until(500);
    chk("runcfg_cl", 512'(cl_count), 512'(6));
    chk("runcfg_a5", 512'(reqlog[5]), 512'(48'hA0140));
    configure(64'hC0000, 3, 8'd3);
    chk("recfg_done", 512'(done), 512'(0));
    chk("recfg_cl", 512'(cl_count), 512'(0));
    run_until(500);
    chk("recfg_a0", 512'(reqlog[0]), 512'(48'hC0000));

    rdy_pct = 100; rd_pct = 50; resp_pct = 50;
    configure(64'hD0000, 10, 8'd3);
    repeat (8) cyc();
    do_reset();
    configure(64'hE0000, 5, 8'd3);
    run_until(1000);
    chk("post_rst_cl", 512'(cl_count), 512'(5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
